mem_access_stage: RTL and testbench

//  MEM stage directly downstream of the 64-bit ALU. Takes one executed instruction per handshake:
//  ALU result BusW, store data BusB, destination Rd and control bits.
//  Non-memory ops pass BusW to writeback. LDUR/STUR-style ops use BusW as a doubleword address and run
//  a req/ack transaction with data memory, which has variable latency. While a transaction is open,

---
 rtl/mem_access_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage downstream of the ALU.
// Non-memory ops pass BusW straight to writeback.
// Loads and stores run one req/ack transaction with a variable-latency data memory.
// InReady is held low while that transaction is open.
// Optional feature macro: MEM_ALIGN_CHECK_EN.
// When defined, a misaligned memory op faults and issues no request.
module mem_access_stage #(
  parameter int n    = 64,
  parameter int RD_W = 5
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [n-1:0]    BusW,
  input  logic [n-1:0]    BusB,
  input  logic [RD_W-1:0] Rd,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic            MemWrite,
  output logic            MemReq,
  output logic            MemWE,
  output logic [n-1:0]    MemAddr,
  output logic [n-1:0]    MemWData,
  input  logic            MemAck,
  input  logic [n-1:0]    MemRData,
  output logic            OutValid,
  output logic [n-1:0]    WBData,
  output logic [RD_W-1:0] WBRd,
  output logic            WBRegWrite,
  output logic            Fault
);

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    addr_q, addr_d;
  logic [n-1:0]    wdata_q, wdata_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            regwrite_q, regwrite_d;
  logic            is_store_q, is_store_d;
  logic            out_valid_q, out_valid_d;
  logic [n-1:0]    wb_data_q, wb_data_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_regwrite_q, wb_regwrite_d;
  logic            transfer;
  logic            mem_op;

  assign InReady  = (state_q == IDLE) && !Reset;
  assign transfer = InValid && InReady;
  assign mem_op   = MemRead || MemWrite;

  assign MemReq     = (state_q == MEM);
  assign MemWE      = MemReq && is_store_q;
  assign MemAddr    = addr_q;
  assign MemWData   = wdata_q;
  assign OutValid   = out_valid_q;
  assign WBData     = wb_data_q;
  assign WBRd       = wb_rd_q;
  assign WBRegWrite = wb_regwrite_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;
  assign misaligned = (BusW[2:0] != 3'b000);
  assign Fault      = fault_q;
`else
  assign Fault = 1'b0;
`endif

  // Next-state, request latching and writeback field selection.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    is_store_d    = is_store_q;
    out_valid_d   = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
`ifdef MEM_ALIGN_CHECK_EN
    fault_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          if (!mem_op) begin
            out_valid_d   = 1'b1;
            wb_data_d     = BusW;
            wb_rd_d       = Rd;
            wb_regwrite_d = RegWrite;
`ifdef MEM_ALIGN_CHECK_EN
          end else if (misaligned) begin
            // Misaligned access completes immediately as a fault, never reaching memory.
            out_valid_d   = 1'b1;
            fault_d       = 1'b1;
            wb_data_d     = BusW;
            wb_rd_d       = Rd;
            wb_regwrite_d = 1'b0;
`endif
          end else begin
            state_d    = MEM;
            addr_d     = BusW;
            wdata_d    = BusB;
            rd_d       = Rd;
            regwrite_d = RegWrite;
            // Both MemRead and MemWrite set is treated as a store.
            is_store_d = MemWrite;
          end
        end
      end
      MEM: begin
        if (MemAck) begin
          state_d       = IDLE;
          out_valid_d   = 1'b1;
          wb_rd_d       = rd_q;
          wb_data_d     = is_store_q ? addr_q : MemRData;
          wb_regwrite_d = !is_store_q && regwrite_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; synchronous reset aborts any open transaction.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      is_store_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      is_store_q    <= is_store_d;
      out_valid_q   <= out_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
`ifdef MEM_ALIGN_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
// Honours MEM_ALIGN_CHECK_EN to select the expected misaligned-load behaviour.
module tb_mem_access_stage;

  localparam int N    = 64;
  localparam int RD_W = 5;

  logic            CLK = 1'b0;
  logic            Reset, InValid, InReady;
  logic [N-1:0]    BusW, BusB;
  logic [RD_W-1:0] Rd;
  logic            RegWrite, MemRead, MemWrite;
  logic            MemReq, MemWE;
  logic [N-1:0]    MemAddr, MemWData;
  logic            MemAck;
  logic [N-1:0]    MemRData;
  logic            OutValid;
  logic [N-1:0]    WBData;
  logic [RD_W-1:0] WBRd;
  logic            WBRegWrite, Fault;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.n(N), .RD_W(RD_W)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .BusW(BusW), .BusB(BusB), .Rd(Rd), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData),
    .OutValid(OutValid), .WBData(WBData), .WBRd(WBRd),
    .WBRegWrite(WBRegWrite), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    InValid  = 1'b0;
    BusW     = '0;
    BusB     = '0;
    Rd       = '0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemAck   = 1'b0;
    MemRData = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL reset_inready_low got=%b exp=0", InReady); end
    step();
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b exp=0", MemReq); end
    Reset = 1'b0;
    #1;
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL reset_inready_high got=%b exp=1", InReady); end
    step();
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", Fault); end
    total++; if (WBData !== 64'h0) begin bad++; $display("FAIL reset_wbdata got=%h exp=0", WBData); end
    total++; if (WBRd !== 5'd0) begin bad++; $display("FAIL reset_wbrd got=%0d exp=0", WBRd); end
    total++; if (MemAddr !== 64'h0) begin bad++; $display("FAIL reset_memaddr got=%h exp=0", MemAddr); end
    total++; if (MemWE !== 1'b0) begin bad++; $display("FAIL reset_memwe got=%b exp=0", MemWE); end
  endtask

  task automatic test_passthrough();
    InValid = 1'b1; BusW = 64'h1234; Rd = 5'd5; RegWrite = 1'b1;
    step();
    idle_inputs();
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL add_outvalid got=%b exp=1", OutValid); end
    total++; if (WBData !== 64'h1234) begin bad++; $display("FAIL add_wbdata got=%h exp=1234", WBData); end
    total++; if (WBRd !== 5'd5) begin bad++; $display("FAIL add_wbrd got=%0d exp=5", WBRd); end
    total++; if (WBRegWrite !== 1'b1) begin bad++; $display("FAIL add_wbregwrite got=%b exp=1", WBRegWrite); end
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL add_memreq got=%b exp=0", MemReq); end
    step();
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b exp=0", OutValid); end
    total++; if (WBData !== 64'h1234) begin bad++; $display("FAIL add_hold got=%h exp=1234", WBData); end
    // An ack with no open transaction must be ignored.
    MemAck = 1'b1; MemRData = 64'h5555;
    step();
    MemAck = 1'b0;
    total++; if (OutValid !== 1'b0 || MemReq !== 1'b0) begin bad++; $display("FAIL idle_ack_ignored got=%b%b exp=00", OutValid, MemReq); end
    total++; if (WBData !== 64'h1234) begin bad++; $display("FAIL idle_ack_wbdata got=%h exp=1234", WBData); end
  endtask

  task automatic test_load();
    InValid = 1'b1; BusW = 64'h40; MemRead = 1'b1; Rd = 5'd9; RegWrite = 1'b1;
    step();
    // Scramble the EX inputs to prove the request is latched.
    idle_inputs();
    BusW = 64'hFFFF; BusB = 64'hAAAA;
    for (int i = 0; i < 3; i++) begin
      total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL load_memreq[%0d] got=%b exp=1", i, MemReq); end
      total++; if (MemWE !== 1'b0) begin bad++; $display("FAIL load_memwe[%0d] got=%b exp=0", i, MemWE); end
      total++; if (MemAddr !== 64'h40) begin bad++; $display("FAIL load_memaddr[%0d] got=%h exp=40", i, MemAddr); end
      total++; if (InReady !== 1'b0) begin bad++; $display("FAIL load_inready[%0d] got=%b exp=0", i, InReady); end
      total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL load_early_out[%0d] got=%b exp=0", i, OutValid); end
      step();
    end
    MemAck = 1'b1; MemRData = 64'hDEADBEEF;
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL load_memreq_ack got=%b exp=1", MemReq); end
    step();
    MemAck = 1'b0; MemRData = '0;
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL load_outvalid got=%b exp=1", OutValid); end
    total++; if (WBData !== 64'hDEADBEEF) begin bad++; $display("FAIL load_wbdata got=%h exp=deadbeef", WBData); end
    total++; if (WBRd !== 5'd9) begin bad++; $display("FAIL load_wbrd got=%0d exp=9", WBRd); end
    total++; if (WBRegWrite !== 1'b1) begin bad++; $display("FAIL load_wbregwrite got=%b exp=1", WBRegWrite); end
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL load_memreq_drop got=%b exp=0", MemReq); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL load_inready_back got=%b exp=1", InReady); end
    idle_inputs();
    step();
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL load_pulse got=%b exp=0", OutValid); end
  endtask

  task automatic test_back_to_back();
    InValid = 1'b1; BusW = 64'h80; BusB = 64'hCAFE; MemWrite = 1'b1; RegWrite = 1'b1; Rd = 5'd3;
    step();
    idle_inputs();
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL store_memreq got=%b exp=1", MemReq); end
    total++; if (MemWE !== 1'b1) begin bad++; $display("FAIL store_memwe got=%b exp=1", MemWE); end
    total++; if (MemWData !== 64'hCAFE) begin bad++; $display("FAIL store_wdata got=%h exp=cafe", MemWData); end
    total++; if (MemAddr !== 64'h80) begin bad++; $display("FAIL store_addr got=%h exp=80", MemAddr); end
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL store_outvalid got=%b exp=1", OutValid); end
    total++; if (WBRegWrite !== 1'b0) begin bad++; $display("FAIL store_wbregwrite got=%b exp=0", WBRegWrite); end
    total++; if (WBData !== 64'h80) begin bad++; $display("FAIL store_wbdata got=%h exp=80", WBData); end
    // ADD offered in the cycle the store's OutValid pulses.
    InValid = 1'b1; BusW = 64'h77; Rd = 5'd7; RegWrite = 1'b1;
    #1;
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL b2b_inready got=%b exp=1", InReady); end
    step();
    idle_inputs();
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL b2b_outvalid got=%b exp=1", OutValid); end
    total++; if (WBData !== 64'h77 || WBRd !== 5'd7) begin bad++; $display("FAIL b2b_wb got=%h/%0d exp=77/7", WBData, WBRd); end
    // MemRead and MemWrite together behave as a store.
    InValid = 1'b1; BusW = 64'h88; BusB = 64'h55; MemRead = 1'b1; MemWrite = 1'b1; RegWrite = 1'b1; Rd = 5'd1;
    step();
    idle_inputs();
    total++; if (MemWE !== 1'b1) begin bad++; $display("FAIL both_memwe got=%b exp=1", MemWE); end
    MemAck = 1'b1; MemRData = 64'h999;
    step();
    idle_inputs();
    total++; if (WBData !== 64'h88 || WBRegWrite !== 1'b0) begin bad++; $display("FAIL both_wb got=%h/%b exp=88/0", WBData, WBRegWrite); end
    step();
  endtask

  task automatic test_reset_abort();
    InValid = 1'b1; BusW = 64'h100; MemRead = 1'b1; Rd = 5'd4; RegWrite = 1'b1;
    step();
    idle_inputs();
    total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL abort_pre_memreq got=%b exp=1", MemReq); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL abort_memreq got=%b exp=0", MemReq); end
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL abort_outvalid got=%b exp=0", OutValid); end
    MemAck = 1'b1; MemRData = 64'hBAD;
    step();
    MemAck = 1'b0;
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL abort_late_ack got=%b exp=0", OutValid); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b exp=1", InReady); end
    total++; if (WBData !== 64'h0) begin bad++; $display("FAIL abort_wbdata got=%h exp=0", WBData); end
    step();
  endtask

  task automatic test_align();
    InValid = 1'b1; BusW = 64'h44; MemRead = 1'b1; Rd = 5'd2; RegWrite = 1'b1;
    step();
    idle_inputs();
`ifdef MEM_ALIGN_CHECK_EN
    total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL align_memreq got=%b exp=0", MemReq); end
    total++; if (OutValid !== 1'b1 || Fault !== 1'b1) begin bad++; $display("FAIL align_fault got=%b%b exp=11", OutValid, Fault); end
    total++; if (WBRegWrite !== 1'b0 || WBData !== 64'h44) begin bad++; $display("FAIL align_wb got=%b/%h exp=0/44", WBRegWrite, WBData); end
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL align_inready got=%b exp=1", InReady); end
    step();
    total++; if (Fault !== 1'b0 || OutValid !== 1'b0) begin bad++; $display("FAIL align_clear got=%b%b exp=00", OutValid, Fault); end
`else
    total++; if (MemReq !== 1'b1 || MemAddr !== 64'h44) begin bad++; $display("FAIL noalign_req got=%b/%h exp=1/44", MemReq, MemAddr); end
    MemAck = 1'b1; MemRData = 64'h4444;
    step();
    idle_inputs();
    total++; if (OutValid !== 1'b1 || Fault !== 1'b0) begin bad++; $display("FAIL noalign_done got=%b%b exp=10", OutValid, Fault); end
    total++; if (WBData !== 64'h4444) begin bad++; $display("FAIL noalign_wbdata got=%h exp=4444", WBData); end
    step();
`endif
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_load();
    test_back_to_back();
    test_reset_abort();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
